pattern_merge_pipe: RTL and testbench

Parametrised successor to the fixed two-pattern merge netlists. It applies a selectable gate-pattern transform (AND/NOR/NAND/XOR of each word with its 1-bit left rotation) over DEPTH registered stages, across WIDTH lanes. Upstream and downstream use valid/ready handshakes. An output beat counter and a rolling signature register support pattern-graph regression. It sits between generated combinational pattern blocks and the capture/compare logic of the sequential test harness.

---
 rtl/pattern_merge_pkg.sv | 16 +
 rtl/pattern_merge_stage.sv | 31 +++
 rtl/pattern_merge_pipe.sv | 60 ++++++
 tb/tb_pattern_merge_pipe.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pattern_merge_pkg.sv
// pattern_merge_pkg: shared mode encoding and gate-pattern transform helpers
package pattern_merge_pkg;
  localparam int PM_W = 64;
  typedef enum logic [1:0] {MODE_AND, MODE_NOR, MODE_NAND, MODE_XOR} mode_t;
  function automatic logic [PM_W-1:0] rotl1(input logic [PM_W-1:0] x, input int w);
    logic [PM_W-1:0] m;
    m = {PM_W{1'b1}} >> (PM_W - w);
    return ((x << 1) | (x >> (w - 1))) & m;
  endfunction
  function automatic logic [PM_W-1:0] pattern_op(input mode_t mode, input logic [PM_W-1:0] x, input int w);
    logic [PM_W-1:0] r, m;
    r = rotl1(x, w);
    m = {PM_W{1'b1}} >> (PM_W - w);
    return (mode == MODE_AND ? x & r : mode == MODE_NOR ? ~(x | r) : mode == MODE_NAND ? ~(x & r) : x ^ r) & m;
  endfunction
endpackage

// File: rtl/pattern_merge_stage.sv
// pattern_merge_stage: one registered transform stage carrying {valid, mode, data}
module pattern_merge_stage
  import pattern_merge_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH+2:0] d,
  output logic [WIDTH+2:0] q
);
  logic             v;
  logic [1:0]       m;
  logic [WIDTH-1:0] dt;
  assign q = {v, m, dt};
  // load the transformed upstream beat; bubbles clear valid but keep the last word
  always_ff @(posedge clk) begin
    if (rst) begin
      v  <= 1'b0;
      m  <= 2'b00;
      dt <= '0;
    end else if (load) begin
      v <= d[WIDTH+2];
      if (d[WIDTH+2]) begin
        m  <= d[WIDTH+1:WIDTH];
        dt <= WIDTH'(pattern_op(mode_t'(d[WIDTH+1:WIDTH]), PM_W'(d[WIDTH-1:0]), WIDTH));
      end
    end
  end
endmodule

// File: rtl/pattern_merge_pipe.sv
// pattern_merge_pipe: DEPTH-stage gate-pattern transform pipe with beat counter and signature
module pattern_merge_pipe
  import pattern_merge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             sig_clear,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] beat_count,
  output logic             cnt_wrap
);
  typedef struct packed {
    logic             valid;
    mode_t            mode;
    logic [WIDTH-1:0] data;
  } stage_t;
  stage_t           st [DEPTH];
  logic [DEPTH-1:0] adv;
  logic             hs;
  assign out_valid = st[DEPTH-1].valid;
  assign out_data  = st[DEPTH-1].data;
  assign hs        = out_valid && out_ready;
  assign adv[DEPTH-1] = hs;
  assign in_ready  = !blif_reset_net && (!st[0].valid || adv[0]);
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k < DEPTH - 1) begin : g_adv
      assign adv[k] = !st[k+1].valid || adv[k+1];
    end
    pattern_merge_stage #(.WIDTH(WIDTH)) u_stage (
      .clk  (blif_clk_net),
      .rst  (blif_reset_net),
      .load (!st[k].valid || adv[k]),
      .d    (k == 0 ? {in_valid, in_mode, in_data} : st[(k == 0) ? 0 : k-1]),
      .q    (st[k])
    );
  end
  // count and fold each accepted output word; clear takes effect before the fold
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      signature  <= '0;
      beat_count <= '0;
      cnt_wrap   <= 1'b0;
    end else begin
      signature <= sig_clear ? (hs ? out_data : '0) : (hs ? {signature[WIDTH-2:0], signature[WIDTH-1]} ^ out_data : signature);
      if (hs) beat_count <= beat_count + 1'b1;
      if (hs && &beat_count) cnt_wrap <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pattern_merge_pipe.sv
// tb_pattern_merge_pipe: directed self-checking bench for pattern_merge_pipe
module tb_pattern_merge_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       sig_clear;
  logic [7:0] signature;
  logic [3:0] beat_count;
  logic       cnt_wrap;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pattern_merge_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(4)) dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_mode        (in_mode),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .sig_clear      (sig_clear),
    .signature      (signature),
    .beat_count     (beat_count),
    .cnt_wrap       (cnt_wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_mode = 2'b00; out_ready = 1'b0; sig_clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_mode = 2'b00; out_ready = 1'b1; sig_clear = 1'b0;
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if ({signature, beat_count, cnt_wrap} !== 13'h0) begin failures++; $display("FAIL reset_counters got=%h/%h/%b exp=0", signature, beat_count, cnt_wrap); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single_xor();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5; in_mode = 2'b11;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h33) begin failures++; $display("FAIL single_out got=%b/%h exp=1/33", out_valid, out_data); end
    tick();
    checks++; if (signature !== 8'h33 || beat_count !== 4'd1) begin failures++; $display("FAIL single_sig_cnt got=%h/%0d exp=33/1", signature, beat_count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4] = '{8'h00, 8'hCF, 8'h03, 8'h33};
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 4); in_data = 8'hA5; in_mode = 2'(c);
      tick();
      if (c >= 1 && c <= 4) begin
        checks++; if (out_valid !== 1'b1 || out_data !== exp[c-1]) begin failures++; $display("FAIL b2b_beat%0d got=%b/%h exp=1/%h", c-1, out_valid, out_data, exp[c-1]); end
      end
    end
    checks++; if (out_valid !== 1'b0 || beat_count !== 4'd4) begin failures++; $display("FAIL b2b_end got=%b/%0d exp=0/4", out_valid, beat_count); end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA5; in_mode = 2'b00;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_rdy0 got=%b exp=1", in_ready); end
    tick();
    in_mode = 2'b01;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_rdy1 got=%b exp=1", in_ready); end
    tick();
    in_mode = 2'b10;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_full_rdy got=%b exp=0", in_ready); end
    tick();
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h00 || in_ready !== 1'b0) begin failures++; $display("FAIL stall_hold got=%b/%h/%b exp=1/00/0", out_valid, out_data, in_ready); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_rdy got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hCF) begin failures++; $display("FAIL stall_out1 got=%b/%h exp=1/CF", out_valid, out_data); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h03) begin failures++; $display("FAIL stall_out2 got=%b/%h exp=1/03", out_valid, out_data); end
    tick();
    checks++; if (out_valid !== 1'b0 || beat_count !== 4'd3) begin failures++; $display("FAIL stall_end got=%b/%0d exp=0/3", out_valid, beat_count); end
  endtask

  task automatic test_signature();
    for (int p = 0; p < 2; p++) begin
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5; in_mode = 2'b11;
      tick();
      tick();
      in_valid = 1'b0;
      tick();
      checks++; if (signature !== 8'h33) begin failures++; $display("FAIL sig_first%0d got=%h exp=33", p, signature); end
      sig_clear = (p == 1);
      tick();
      sig_clear = 1'b0;
      checks++; if (signature !== (p == 1 ? 8'h33 : 8'h55)) begin failures++; $display("FAIL sig_second%0d got=%h exp=%h", p, signature, p == 1 ? 8'h33 : 8'h55); end
    end
    sig_clear = 1'b1;
    tick();
    sig_clear = 1'b0;
    checks++; if (signature !== 8'h00 || beat_count !== 4'd2) begin failures++; $display("FAIL sig_clear_idle got=%h/%0d exp=00/2", signature, beat_count); end
  endtask

  task automatic send_n(input int n);
    out_ready = 1'b1; in_data = 8'h5A; in_mode = 2'b10;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_wrap();
    do_reset();
    send_n(15);
    checks++; if (beat_count !== 4'd15 || cnt_wrap !== 1'b0) begin failures++; $display("FAIL wrap_pre got=%0d/%b exp=15/0", beat_count, cnt_wrap); end
    send_n(1);
    checks++; if (beat_count !== 4'd0 || cnt_wrap !== 1'b1) begin failures++; $display("FAIL wrap_hit got=%0d/%b exp=0/1", beat_count, cnt_wrap); end
    send_n(2);
    checks++; if (beat_count !== 4'd2 || cnt_wrap !== 1'b1) begin failures++; $display("FAIL wrap_sticky got=%0d/%b exp=2/1", beat_count, cnt_wrap); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    send_n(1);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA5; in_mode = 2'b11;
    tick();
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || signature === 8'h00) begin failures++; $display("FAIL mid_prefill got=%b/%h exp=1/nonzero", out_valid, signature); end
    out_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || beat_count !== 4'd0 || signature !== 8'h00) begin failures++; $display("FAIL mid_reset got=%b/%0d/%h exp=0/0/00", out_valid, beat_count, signature); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || beat_count !== 4'd0) begin failures++; $display("FAIL mid_stale%0d got=%b/%0d exp=0/0", i, out_valid, beat_count); end
    end
  endtask

  initial begin
    test_reset();
    test_single_xor();
    test_back_to_back();
    test_stall();
    test_signature();
    test_wrap();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
